data_mem_be: RTL
================

// Module: data_mem_be
// PURPOSE
//  Parametrised successor to the single-port data memory: word-addressed RAM with
//  byte-enable writes, valid/ready request handshake and registered read response.
//  Adds an out-of-range error response and a hardware clear sequencer.
//  Sits between the CPU load/store stage and storage; one request per cycle when idle.
// PARAMETERS
//  DATA_W   32  data width in bits, multiple of 8
//  DEPTH    32  number of words, >=2
//  ADDR_W   32  width of the address port, in words
// PORTS
//  clk        in   1         clock, all logic on posedge
//  reset      in   1         synchronous, active-high
//  req_valid  in   1         request present
//  req_ready  out  1         block accepts a request this cycle
//  req_we     in   1         1=write, 0=read
//  req_addr   in   ADDR_W    word address
//  req_wdata  in   DATA_W    write data
//  req_be     in   DATA_W/8  byte enables, write only
//  rsp_valid  out  1         response pulse, one per accepted request
//  rsp_rdata  out  DATA_W    read data, 0 for writes and errors
//  rsp_err    out  1         address >= DEPTH
//  busy       out  1         clear sequence in progress
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, busy=1, FSM->CLEAR, clr_ptr=0.
//  - FSM states CLEAR, IDLE.
//  - CLEAR: write 0 to mem[clr_ptr] each cycle, clr_ptr++.
//    After writing DEPTH-1, go to IDLE next cycle.
//    CLEAR lasts exactly DEPTH cycles; req_ready=0 and busy=1 throughout.
//  - IDLE: req_ready=1, busy=0. A request is accepted when req_valid && req_ready.
//  - Accepted write, addr<DEPTH: bytes with req_be[i]=1 updated at that edge; others kept.
//    Response next cycle: rsp_valid=1, rsp_err=0, rsp_rdata=0. be=0 is a legal no-op write.
//  - Accepted read, addr<DEPTH: response next cycle: rsp_valid=1, rsp_rdata=mem[addr] (latency 1).
//  - Accepted request, addr>=DEPTH (full ADDR_W compare, no truncation or wrap):
//    no memory change; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
//  - rsp_valid is a 1-cycle pulse. With no accepted request it is 0 and rsp_rdata/rsp_err hold.
//  - Back-to-back: write to A at cycle n, read of A at n+1 returns the new data at n+2
//    (no bypass needed; the write is already committed).
//  - No response backpressure; the consumer must sink rsp every cycle.
//  - Reset mid-CLEAR or mid-traffic restarts CLEAR from 0.
//    Any in-flight response is dropped (rsp_valid=0 the next cycle).
//  - Reset dominates all other inputs.
// CONFIGURATION
//  DMEM_PARITY_EN defined:
//    one even-parity bit per byte stored alongside the data, written with the byte,
//    cleared to 0 by CLEAR.
//    Extra port par_err (out, 1): set with rsp_valid on a read whose stored parity mismatches.
//    Data still returned. par_err is 0 on writes and errors, and 0 at reset.
//  DMEM_PARITY_EN undefined: no parity storage and no par_err port.
// STRUCTURE
//  Package dmem_pkg: state enum {CLEAR, IDLE}; localparams BE_W=DATA_W/8 and
//  IDX_W=$clog2(DEPTH); response struct {valid, err, rdata}.
//  One sub-module, dmem_array: storage plus byte-enable write and registered read
//  (plus parity bits under DMEM_PARITY_EN).
//  The top level holds the FSM, clear pointer, range check and response register.
// TESTING
//  (DATA_W=32, DEPTH=16)
//  1. Reset 1 cycle -> busy=1, req_ready=0 for exactly 16 cycles. Then a read of every
//     address returns 0, rsp_err=0.
//  2. Write A=3, D=32'hDEADBEEF, be=4'hF; then write A=3, D=32'h00000011, be=4'h1;
//     read A=3 -> rsp_rdata=32'hDEADBE11 one cycle after the read is accepted.
//  3. Read A=16 and A=32'hFFFFFFFF -> rsp_valid=1, rsp_err=1, rsp_rdata=0.
//     Write A=16 -> rsp_err=1, and a full read sweep shows no changes.
//  4. Back-to-back writes to A=0..15 followed by back-to-back reads: one response per
//     cycle, data=A*32'h01010101, no gaps.
//  5. Assert reset during CLEAR at cycle 7 and during a pending read -> rsp_valid=0 next
//     cycle, CLEAR restarts, full 16 cycles counted again.
//  6. DMEM_PARITY_EN: force-flip one stored data bit at A=5, then read A=5 ->
//     par_err=1 with rsp_valid; read A=6 -> par_err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-enable data memory.
// Optional parity storage is selected with the DMEM_PARITY_EN macro.
package dmem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Response control flags; the read data itself lives in the array's read register.
    typedef struct packed {
        logic valid;
        logic err;
    } rsp_flags_t;

    // Byte-enable width for a given data width (data width is a multiple of 8).
    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

    // Word-index width for a given depth; at least one bit.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Even parity of one byte: the stored bit makes the 9-bit group have an even count of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-lane writes and a registered read port.
// With DMEM_PARITY_EN defined, one even-parity bit per byte is stored and
// checked on every read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int BE_W   = be_w(DATA_W),
    localparam int IDX_W  = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    input  logic              i_re,
    input  logic              i_rclr,
`ifdef DMEM_PARITY_EN
    output logic              o_par_err,
`endif
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Byte-lane write port: only enabled bytes of the addressed word change.
    // NOTE: the storage array has no reset branch; the clear sequencer zeroes it,
    // which keeps it mappable onto plain RAM.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read register: loads on a read, zeroes on a write/error response, otherwise holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end else if (i_rclr) begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

`ifdef DMEM_PARITY_EN
    logic [BE_W-1:0] r_par [DEPTH];
    logic [BE_W-1:0] w_par_calc;
    logic            w_par_mis;
    logic            r_par_err;

    // Parity bits follow their byte: written under the same byte enable.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_par[i_addr][b] <= byte_parity(i_wdata[b*8 +: 8]);
                end
            end
        end
    end

    // Recompute parity of the addressed word for comparison with the stored bits.
    always_comb begin
        w_par_calc = '0;
        for (int b = 0; b < BE_W; b++) begin
            w_par_calc[b] = byte_parity(r_mem[i_addr][b*8 +: 8]);
        end
    end

    assign w_par_mis = |(w_par_calc ^ r_par[i_addr]);

    // Parity error flag travels with the read data and is zero on other responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_err <= 1'b0;
        end else if (i_re) begin
            r_par_err <= w_par_mis;
        end else if (i_rclr) begin
            r_par_err <= 1'b0;
        end
    end

    assign o_par_err = r_par_err;
`endif

endmodule

// File: rtl/data_mem_be.sv
// Word-addressed data memory with byte-enable writes, valid/ready requests,
// one-cycle registered responses, out-of-range error responses and a
// hardware clear sequence after reset. Macro DMEM_PARITY_EN adds per-byte
// parity storage and the o_par_err output.
module data_mem_be
    import dmem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    parameter  int ADDR_W = 32,
    localparam int BE_W   = be_w(DATA_W),
    localparam int IDX_W  = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [BE_W-1:0]   i_req_be,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
`ifdef DMEM_PARITY_EN
    output logic              o_par_err,
`endif
    output logic              o_busy
);

    // Depth widened by one bit so the range check sees every address bit.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    state_e            r_state;
    state_e            w_state_next;
    logic [IDX_W-1:0]  r_clr_ptr;
    logic              w_clr_last;
    logic              w_ready;
    logic              w_accept;
    logic              w_oor;
    rsp_flags_t        r_rsp;

    logic              w_arr_we;
    logic [IDX_W-1:0]  w_arr_addr;
    logic [DATA_W-1:0] w_arr_wdata;
    logic [BE_W-1:0]   w_arr_be;
    logic              w_arr_re;
    logic              w_arr_rclr;
    logic [DATA_W-1:0] w_arr_rdata;

    assign w_clr_last = (r_clr_ptr == IDX_W'(DEPTH - 1));
    assign w_ready    = (r_state == ST_IDLE) && !reset;
    assign w_accept   = i_req_valid && w_ready;
    assign w_oor      = ({1'b0, i_req_addr} >= DEPTH_EXT);

    // State register; reset always restarts the clear sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear pointer walks 0..DEPTH-1 once per clear sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_ptr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_ptr <= w_clr_last ? '0 : r_clr_ptr + 1'b1;
        end
    end

    // Next state, handshake outputs and array port steering.
    // NOTE: every output of this block gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b1;
        w_arr_we     = 1'b0;
        w_arr_addr   = r_clr_ptr;
        w_arr_wdata  = '0;
        w_arr_be     = '1;
        w_arr_re     = 1'b0;
        w_arr_rclr   = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_arr_we = !reset;
                if (w_clr_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                o_busy      = reset;
                w_arr_addr  = i_req_addr[IDX_W-1:0];
                w_arr_wdata = i_req_wdata;
                w_arr_be    = i_req_be;
                if (w_accept) begin
                    w_arr_we   = i_req_we && !w_oor;
                    w_arr_re   = !i_req_we && !w_oor;
                    w_arr_rclr = i_req_we || w_oor;
                end
            end
            default: w_state_next = ST_CLEAR;
        endcase
    end

    assign o_req_ready = w_ready;

    // Response flags: one-cycle valid pulse, error flag held between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp <= '0;
        end else begin
            r_rsp.valid <= w_accept;
            if (w_accept) begin
                r_rsp.err <= w_oor;
            end
        end
    end

    assign o_rsp_valid = r_rsp.valid;
    assign o_rsp_err   = r_rsp.err;
    assign o_rsp_rdata = w_arr_rdata;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_arr_we),
        .i_addr    (w_arr_addr),
        .i_wdata   (w_arr_wdata),
        .i_be      (w_arr_be),
        .i_re      (w_arr_re),
        .i_rclr    (w_arr_rclr),
`ifdef DMEM_PARITY_EN
        .o_par_err (o_par_err),
`endif
        .o_rdata   (w_arr_rdata)
    );

endmodule
